// File: rtl/pkt_sanitizer_pkg.sv
// Shared types for the packet sanitizer: FSM states, beat layout and statistic indices.
package pkt_sanitizer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PASS,
        ST_FLUSH,
        ST_DROP
    } state_t;

    localparam int DWIDTH_DEFAULT = 32;

    // Beat layout at the default data width; the top keeps its fields as separate vectors.
    typedef struct packed {
        logic [DWIDTH_DEFAULT-1:0] data;
        logic                      sop;
        logic                      eop;
    } beat_t;

    localparam int STAT_ORPHAN = 0;
    localparam int STAT_FIX    = 1;
    localparam int STAT_TRUNC  = 2;
    localparam int NUM_STATS   = 3;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pkt_sanitizer.sv
// Repairs a SOP/EOP framed stream: drops orphans, closes unterminated packets, truncates long ones.
// Statistic counters are built only when PKT_SANITIZER_STATS_EN is defined.
module pkt_sanitizer
    import pkt_sanitizer_pkg::*;
#(
    parameter int DWIDTH      = 32,
    parameter int MAX_PKT_LEN = 1024,
    parameter int CNT_W       = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [DWIDTH-1:0] snk_data_i,
    input  logic              snk_startofpacket_i,
    input  logic              snk_endofpacket_i,
    input  logic              snk_valid_i,
    output logic              snk_ready_o,
    output logic [DWIDTH-1:0] src_data_o,
    output logic              src_startofpacket_o,
    output logic              src_endofpacket_o,
    output logic              src_valid_o,
    input  logic              src_ready_i,
    output logic [CNT_W-1:0]  orphan_cnt_o,
    output logic [CNT_W-1:0]  fix_cnt_o,
    output logic [CNT_W-1:0]  trunc_cnt_o
);

    localparam int CNT_BW = $clog2(MAX_PKT_LEN + 1);
    localparam logic [CNT_BW-1:0] LIMIT_CNT = CNT_BW'(MAX_PKT_LEN - 1);

    state_t            state_reg;
    logic [DWIDTH-1:0] hold_data_reg;
    logic              hold_sop_reg;
    logic [CNT_BW-1:0] cnt_reg;
    logic              drop_after_reg;
    logic [DWIDTH-1:0] out_data_reg;
    logic              out_sop_reg;
    logic              out_eop_reg;
    logic              out_valid_reg;

    logic out_free;
    logic accept;
    logic at_limit;

    assign out_free = !out_valid_reg || src_ready_i;
    assign accept   = snk_valid_i && snk_ready_o;
    // The incoming beat would be the last one allowed; without EOP it must be cut here.
    assign at_limit = (cnt_reg == LIMIT_CNT);

    always_comb begin
        snk_ready_o = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DROP: snk_ready_o = 1'b1;
            ST_PASS:          snk_ready_o = out_free;
            default:          snk_ready_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg      <= ST_IDLE;
            hold_data_reg  <= '0;
            hold_sop_reg   <= 1'b0;
            cnt_reg        <= '0;
            drop_after_reg <= 1'b0;
            out_data_reg   <= '0;
            out_sop_reg    <= 1'b0;
            out_eop_reg    <= 1'b0;
            out_valid_reg  <= 1'b0;
        end else begin
            if (src_ready_i) begin
                out_valid_reg <= 1'b0;
            end
            case (state_reg)
                ST_IDLE, ST_DROP: begin
                    if (snk_valid_i) begin
                        if (snk_startofpacket_i) begin
                            hold_data_reg  <= snk_data_i;
                            hold_sop_reg   <= 1'b1;
                            cnt_reg        <= CNT_BW'(1);
                            drop_after_reg <= 1'b0;
                            state_reg      <= snk_endofpacket_i ? ST_FLUSH : ST_PASS;
                        end else if ((state_reg == ST_DROP) && snk_endofpacket_i) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                ST_PASS: begin
                    if (accept) begin
                        // A new SOP closes the held beat as the end of the broken packet.
                        out_data_reg  <= hold_data_reg;
                        out_sop_reg   <= hold_sop_reg;
                        out_eop_reg   <= snk_startofpacket_i;
                        out_valid_reg <= 1'b1;
                        hold_data_reg <= snk_data_i;
                        if (snk_startofpacket_i) begin
                            hold_sop_reg   <= 1'b1;
                            cnt_reg        <= CNT_BW'(1);
                            drop_after_reg <= 1'b0;
                            state_reg      <= snk_endofpacket_i ? ST_FLUSH : ST_PASS;
                        end else begin
                            hold_sop_reg <= 1'b0;
                            cnt_reg      <= cnt_reg + CNT_BW'(1);
                            if (snk_endofpacket_i) begin
                                drop_after_reg <= 1'b0;
                                state_reg      <= ST_FLUSH;
                            end else if (at_limit) begin
                                drop_after_reg <= 1'b1;
                                state_reg      <= ST_FLUSH;
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    if (out_free) begin
                        out_data_reg  <= hold_data_reg;
                        out_sop_reg   <= hold_sop_reg;
                        out_eop_reg   <= 1'b1;
                        out_valid_reg <= 1'b1;
                        state_reg     <= drop_after_reg ? ST_DROP : ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign src_data_o          = out_data_reg;
    assign src_startofpacket_o = out_sop_reg;
    assign src_endofpacket_o   = out_eop_reg;
    assign src_valid_o         = out_valid_reg;

`ifdef PKT_SANITIZER_STATS_EN
    logic [NUM_STATS-1:0] stat_inc;
    logic [CNT_W-1:0]     stat_cnt [NUM_STATS];

    assign stat_inc[STAT_ORPHAN] = accept && (state_reg == ST_IDLE) && !snk_startofpacket_i;
    assign stat_inc[STAT_FIX]    = accept && (state_reg == ST_PASS) && snk_startofpacket_i;
    assign stat_inc[STAT_TRUNC]  = accept && (state_reg == ST_PASS) && !snk_startofpacket_i
                                   && !snk_endofpacket_i && at_limit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STATS; gi++) begin : g_stat
            sat_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk_i   (clk_i),
                .rst_n_i (rst_n_i),
                .inc     (stat_inc[gi]),
                .cnt     (stat_cnt[gi])
            );
        end
    endgenerate

    assign orphan_cnt_o = stat_cnt[STAT_ORPHAN];
    assign fix_cnt_o    = stat_cnt[STAT_FIX];
    assign trunc_cnt_o  = stat_cnt[STAT_TRUNC];
`else
    assign orphan_cnt_o = '0;
    assign fix_cnt_o    = '0;
    assign trunc_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_pkt_sanitizer.sv
// Directed bench for pkt_sanitizer with MAX_PKT_LEN=4; counter expectations follow PKT_SANITIZER_STATS_EN.
module tb_pkt_sanitizer;
    import pkt_sanitizer_pkg::*;

`ifdef PKT_SANITIZER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        rst_n_i;
    logic [31:0] snk_data_i;
    logic        snk_startofpacket_i;
    logic        snk_endofpacket_i;
    logic        snk_valid_i;
    logic        snk_ready_o;
    logic [31:0] src_data_o;
    logic        src_startofpacket_o;
    logic        src_endofpacket_o;
    logic        src_valid_o;
    logic        src_ready_i;
    logic [15:0] orphan_cnt_o;
    logic [15:0] fix_cnt_o;
    logic [15:0] trunc_cnt_o;

    int    errors = 0;
    int    checks = 0;
    bit    rand_mode = 0;
    bit    ready_fixed = 1;
    beat_t got_q[$];
    beat_t exp_q[$];

    pkt_sanitizer #(.DWIDTH(32), .MAX_PKT_LEN(4), .CNT_W(16)) dut (
        .clk_i               (clk),
        .rst_n_i             (rst_n_i),
        .snk_data_i          (snk_data_i),
        .snk_startofpacket_i (snk_startofpacket_i),
        .snk_endofpacket_i   (snk_endofpacket_i),
        .snk_valid_i         (snk_valid_i),
        .snk_ready_o         (snk_ready_o),
        .src_data_o          (src_data_o),
        .src_startofpacket_o (src_startofpacket_o),
        .src_endofpacket_o   (src_endofpacket_o),
        .src_valid_o         (src_valid_o),
        .src_ready_i         (src_ready_i),
        .orphan_cnt_o        (orphan_cnt_o),
        .fix_cnt_o           (fix_cnt_o),
        .trunc_cnt_o         (trunc_cnt_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        src_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            src_ready_i = rand_mode ? 1'($urandom_range(0, 1)) : ready_fixed;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output capture on handshake plus hold-while-stalled check.
    initial begin
        bit    stall_prev;
        beat_t held;
        stall_prev = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n_i) begin
                stall_prev = 0;
            end else begin
                if (stall_prev)
                    chk("stall_hold", {src_valid_o, src_data_o, src_startofpacket_o, src_endofpacket_o},
                        {1'b1, held});
                if (src_valid_o && src_ready_i)
                    got_q.push_back(beat_t'{data: src_data_o, sop: src_startofpacket_o, eop: src_endofpacket_o});
                stall_prev = src_valid_o && !src_ready_i;
                held = beat_t'{data: src_data_o, sop: src_startofpacket_o, eop: src_endofpacket_o};
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic s, input logic e);
        int n;
        n = 0;
        snk_data_i = d;
        snk_startofpacket_i = s;
        snk_endofpacket_i = e;
        snk_valid_i = 1'b1;
        forever begin
            @(negedge clk);
            if (snk_ready_o) break;
            n++;
            if (n > 100) begin
                chk("send_timeout", 64'(snk_ready_o), 64'd1);
                break;
            end
        end
        sync();
        snk_valid_i = 1'b0;
    endtask

    task automatic drain();
        int quiet;
        int n;
        quiet = 0;
        n = 0;
        while (quiet < 3) begin
            @(negedge clk);
            n++;
            quiet = src_valid_o ? 0 : quiet + 1;
            if (n > 300) begin
                chk("drain_timeout", 64'(src_valid_o), 64'd0);
                break;
            end
        end
    endtask

    task automatic ex(input logic [31:0] d, input logic s, input logic e);
        exp_q.push_back(beat_t'{data: d, sop: s, eop: e});
    endtask

    task automatic check_q(input string tag);
        chk({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_cnts(input string tag, input int o, input int f, input int t);
        chk({tag, "_orphan"}, 64'(orphan_cnt_o), STATS ? 64'(o) : 64'd0);
        chk({tag, "_fix"},    64'(fix_cnt_o),    STATS ? 64'(f) : 64'd0);
        chk({tag, "_trunc"},  64'(trunc_cnt_o),  STATS ? 64'(t) : 64'd0);
    endtask

    initial begin
        rst_n_i = 1'b0;
        snk_data_i = '0;
        snk_startofpacket_i = 1'b0;
        snk_endofpacket_i = 1'b0;
        snk_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(src_valid_o), 64'd0);
        chk("rst_sop_eop", 64'({src_startofpacket_o, src_endofpacket_o}), 64'd0);
        chk("rst_data", 64'(src_data_o), 64'd0);
        chk("rst_ready", 64'(snk_ready_o), 64'd1);
        check_cnts("rst", 0, 0, 0);
        rst_n_i = 1'b1;

        // Plain 4-beat packet, exactly MAX_PKT_LEN long with EOP: not truncated.
        sync();
        send(1, 1, 0); send(2, 0, 0); send(3, 0, 0); send(4, 0, 1);
        drain();
        ex(1, 1, 0); ex(2, 0, 0); ex(3, 0, 0); ex(4, 0, 1);
        check_q("pkt4");
        check_cnts("pkt4", 0, 0, 0);

        // Orphans ahead of a packet.
        sync();
        send(7, 0, 0); send(8, 0, 0); send(5, 1, 0); send(6, 0, 1);
        drain();
        ex(5, 1, 0); ex(6, 0, 1);
        check_q("orphan");
        check_cnts("orphan", 2, 0, 0);

        // Missing EOP fixed by the next SOP.
        sync();
        send(1, 1, 0); send(2, 0, 0); send(3, 0, 0); send(9, 1, 1);
        drain();
        ex(1, 1, 0); ex(2, 0, 0); ex(3, 0, 1); ex(9, 1, 1);
        check_q("fix");
        check_cnts("fix", 2, 1, 0);

        // 6-beat packet cut at 4; tail dropped without orphan counting.
        sync();
        for (int i = 1; i <= 6; i++) send(32'(i), i == 1, i == 6);
        drain();
        ex(1, 1, 0); ex(2, 0, 0); ex(3, 0, 0); ex(4, 0, 1);
        check_q("trunc");
        check_cnts("trunc", 2, 1, 1);

        // Random backpressure.
        rand_mode = 1;
        sync();
        send(1, 1, 0); send(2, 0, 0); send(3, 0, 0); send(4, 0, 1);
        drain();
        rand_mode = 0;
        ready_fixed = 1;
        repeat (2) sync();
        drain();
        ex(1, 1, 0); ex(2, 0, 0); ex(3, 0, 0); ex(4, 0, 1);
        check_q("backpressure");

        // Single-beat latency: accepted at edge E, valid after E+1.
        sync();
        snk_data_i = 32'hA; snk_startofpacket_i = 1'b1; snk_endofpacket_i = 1'b1; snk_valid_i = 1'b1;
        @(posedge clk);
        #1;
        snk_valid_i = 1'b0;
        chk("lat_e0_valid", 64'(src_valid_o), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_e1_beat", {src_valid_o, src_data_o, src_startofpacket_o, src_endofpacket_o},
            {1'b1, 32'hA, 1'b1, 1'b1});
        drain();
        ex(32'hA, 1, 1);
        check_q("single");

        // Asynchronous reset mid-packet while output is stalled.
        ready_fixed = 0;
        repeat (2) sync();
        send(1, 1, 0); send(2, 0, 0);
        chk("pre_rst_valid", 64'(src_valid_o), 64'd1);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("arst_out", {src_valid_o, src_data_o, src_startofpacket_o, src_endofpacket_o}, 64'd0);
        check_cnts("arst", 0, 0, 0);
        @(negedge clk);
        rst_n_i = 1'b1;
        ready_fixed = 1;
        repeat (2) sync();
        got_q.delete();
        send(5, 1, 0); send(6, 0, 1);
        drain();
        ex(5, 1, 0); ex(6, 0, 1);
        check_q("post_rst");
        check_cnts("post_rst", 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pkt_sanitizer.md
PKT_SANITIZER -- requirements
Module: pkt_sanitizer

Interface
REQ-001 Parameter DWIDTH, default 32, data width in bits.
REQ-002 Parameter MAX_PKT_LEN, default 1024, maximum output packet length in beats; SHALL be >= 2.
REQ-003 Parameter CNT_W, default 16, statistics counter width.
REQ-004 Clock, reset and streaming ports SHALL be:
- clk_i  in  1  single clock; all logic on rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- snk_data_i  in  DWIDTH  input beat data.
- snk_startofpacket_i  in  1  input SOP.
- snk_endofpacket_i  in  1  input EOP.
- snk_valid_i  in  1  input beat valid.
- snk_ready_o  out  1  input beat accepted when valid&ready.
- src_data_o  out  DWIDTH  output data, registered.
- src_startofpacket_o  out  1  output SOP, registered.
- src_endofpacket_o  out  1  output EOP, registered.
- src_valid_o  out  1  output valid, registered.
- src_ready_i  in  1  downstream (sorter) ready.
- orphan_cnt_o  out  CNT_W  beats discarded outside a packet.
- fix_cnt_o  out  CNT_W  packets closed by forced EOP (missing EOP).
- trunc_cnt_o  out  CNT_W  packets truncated at MAX_PKT_LEN.

Function
REQ-005 Block SHALL hold one accepted beat in hold register H plus a beat counter (width $clog2(MAX_PKT_LEN+1)); H is emitted only once its EOP status is known.
REQ-006 FSM states SHALL be IDLE, PASS, FLUSH, DROP.
REQ-007 snk_ready_o SHALL be 1 in IDLE and DROP, (!src_valid_o | src_ready_i) in PASS, 0 in FLUSH.
REQ-008 IDLE: beat without SOP discarded, orphan count +1; beat with SOP loaded into H, cnt=1, next PASS, or FLUSH if it also has EOP.
REQ-009 PASS, accepted beat without SOP: H emitted with EOP=0, beat loaded into H, cnt+1; if beat has EOP -> FLUSH (drop_after=0).
REQ-010 PASS, accepted beat that would be beat MAX_PKT_LEN without EOP: loaded with EOP forced, trunc count +1, -> FLUSH (drop_after=1).
REQ-011 PASS, accepted beat with SOP: H emitted with EOP forced 1, fix count +1, new beat loaded as packet start (cnt=1), stay PASS (or FLUSH if it has EOP).
REQ-012 FLUSH: when (!src_valid_o | src_ready_i), H emitted with EOP=1, next IDLE (drop_after=0) or DROP (drop_after=1).
REQ-013 DROP: beats discarded; EOP beat -> IDLE; SOP beat handled as in IDLE (new packet start).
REQ-014 Output register SHALL hold data/SOP/EOP stable while src_valid_o=1 and src_ready_i=0; src_valid_o drops after handshake if nothing new loaded.
REQ-015 Single-beat packet accepted at edge E SHALL appear with src_valid_o=1 after edge E+1 when downstream is ready.
REQ-016 Output SHALL always satisfy: SOP first, EOP last, no beats between packets, length 1..MAX_PKT_LEN.
REQ-017 Statistics counters SHALL saturate at all-ones.

Reset
REQ-018 rst_n_i low SHALL immediately force state IDLE, H empty, cnt 0, src_valid_o/SOP/EOP 0, src_data_o 0, all counters 0; in-flight packet discarded.
REQ-019 First beat after reset release SHALL be treated per IDLE rules.

Configuration
REQ-020 Macro PKT_SANITIZER_STATS_EN defined: three counters implemented per REQ-008/010/011/017.
REQ-021 Macro undefined: counter ports present, driven constant 0, no counter logic; data path identical.

Structure
REQ-022 Package pkt_sanitizer_pkg SHALL hold the state enum and a beat struct typedef (data, sop, eop).
REQ-023 One sub-module sat_counter (CNT_W, inc, saturating) SHALL implement each statistic.

Verification
REQ-024 Packet of 4 beats 1,2,3,4 with src_ready_i=1 -> identical 4-beat packet out, SOP on 1, EOP on 4, counters 0.
REQ-025 Beats 7,8 without SOP then SOP packet 5,6 -> output 5,6 only, orphan_cnt_o=2.
REQ-026 SOP 1,2,3 then SOP 9 EOP -> output packet 1,2,3 with EOP on 3, then packet 9; fix_cnt_o=1.
REQ-027 MAX_PKT_LEN=4, 6-beat packet 1..6 -> output 1..4, EOP on 4, beats 5,6 dropped, trunc_cnt_o=1.
REQ-028 src_ready_i toggled randomly 50% -> output stream matches REQ-024 reference, data stable while stalled.
REQ-029 rst_n_i pulsed low mid-packet -> outputs 0 asynchronously; next SOP packet passes intact.
